// File: rtl/ofm_writer.sv
// ofm_writer: output-feature-map write-back stage behind the CNN datapath.
// Takes one vector of P signed accumulator lanes per handshake and
// requantizes each lane. Requantization is an arithmetic shift, then an
// optional ReLU, then saturation to OUT_W bits. The lanes are written one per
// cycle to sequential OFM addresses starting at a programmed base address.
// done pulses once the programmed number of words has been written.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             one-cycle pulse, latches base_addr/total_cnt (IDLE only)
//   base_addr         first OFM address of the job
//   total_cnt         number of output words to write (0 = empty job)
//   in_valid/in_data  upstream vector, lane i = in_data[i*ACC_W +: ACC_W]
//   in_ready          high exactly while the stage waits for a vector
//   mem_we/addr/wdata OFM write port (registered, one word per cycle)
//   busy              high in every state except IDLE
//   done              one-cycle completion pulse
module ofm_writer #(
  parameter int P      = 4,
  parameter int ACC_W  = 16,
  parameter int OUT_W  = 8,
  parameter int ADDR_W = 9,
  parameter int SHIFT  = 4,
  parameter int RELU   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     total_cnt,
  input  logic                  in_valid,
  input  logic [P*ACC_W-1:0]    in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [OUT_W-1:0]      mem_wdata,
  output logic                  busy,
  output logic                  done
);

  localparam int LANE_W = (P > 1) ? $clog2(P) : 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(P - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   ptr_r;
  logic [ADDR_W-1:0]   rem_r;
  logic [LANE_W-1:0]   lane_r;
  logic [P*ACC_W-1:0]  buf_r;
  logic [ACC_W-1:0]    lane_word_s;
  logic                xfer_s;

  // Shift (floor), optional ReLU, then clamp into the signed OUT_W range.
  function automatic logic [OUT_W-1:0] requant(input logic [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    logic [OUT_W-1:0]        r;
    s = $signed(a) >>> SHIFT;
    if ((RELU != 0) && (s[ACC_W-1] == 1'b1)) begin
      s = {ACC_W{1'b0}};
    end else begin
      s = s;
    end
    if (s > SAT_MAX) begin
      r = SAT_MAX[OUT_W-1:0];
    end else if (s < SAT_MIN) begin
      r = SAT_MIN[OUT_W-1:0];
    end else begin
      r = s[OUT_W-1:0];
    end
    return r;
  endfunction

  // in_ready mirrors the WAIT state exactly, so it alone qualifies a transfer.
  assign xfer_s = in_valid & in_ready;

  // Select the buffered lane that is being written this cycle.
  always_comb begin
    lane_word_s = buf_r[lane_r*ACC_W +: ACC_W];
  end

  // Next-state decision.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (total_cnt == {ADDR_W{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (xfer_s) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_WRITE: begin
        // The final word ends the job even mid-vector; leftover lanes are dropped.
        if (rem_r == ADDR_W'(1)) begin
          state_s = ST_DONE;
        end else if (lane_r == LANE_LAST) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Job pointer, remaining count, lane index and captured vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r  <= {ADDR_W{1'b0}};
      rem_r  <= {ADDR_W{1'b0}};
      lane_r <= {LANE_W{1'b0}};
      buf_r  <= {(P*ACC_W){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            ptr_r <= base_addr;
            rem_r <= total_cnt;
          end
        end
        ST_WAIT: begin
          if (xfer_s) begin
            buf_r  <= in_data;
            lane_r <= {LANE_W{1'b0}};
          end
        end
        ST_WRITE: begin
          ptr_r  <= ptr_r + ADDR_W'(1);
          rem_r  <= rem_r - ADDR_W'(1);
          lane_r <= lane_r + LANE_W'(1);
        end
        default: begin
          ptr_r <= ptr_r;
        end
      endcase
    end
  end

  // Registered outputs. Handshake/busy track the state; the write port and
  // done lag the state decision by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {OUT_W{1'b0}};
    end else begin
      in_ready <= (state_s == ST_WAIT);
      busy     <= (state_s != ST_IDLE);
      done     <= (state_r == ST_DONE);
      mem_we   <= (state_r == ST_WRITE);
      if (state_r == ST_WRITE) begin
        mem_addr  <= ptr_r;
        mem_wdata <= requant(lane_word_s);
      end
    end
  end

endmodule
